// File: rtl/pio_in_edge_irq.sv
// ---------------------------------------------------------------------------
// pio_in_edge_irq
//
// Avalon-MM slave input PIO for board keys and switches. Each of the W
// external input bits is synchronised through two flops and then debounced:
// the debounced level follows the synchronised input only after the input has
// differed from it for DEBOUNCE_CYCLES consecutive clocks. Selected edges of
// the debounced level are latched into a sticky edge-capture register. A level
// interrupt is raised whenever a captured edge is also enabled in the mask.
//
// Register map (word addresses, readdata[31:W] always zero):
//   0 DATA      read debounced level, writes ignored
//   1 DIRECTION reads zero, writes ignored (input-only PIO)
//   2 IRQ_MASK  read/write, bits [W-1:0]
//   3 EDGE_CAP  read captured edges, write-one-to-clear
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   address     register select (2 bits)
//   chipselect  slave select, qualifies writes only
//   write_n     active-low write strobe
//   writedata   32-bit write data
//   readdata    32-bit combinational read data, zero-wait-state
//   in_port     W asynchronous external inputs
//   irq         level interrupt, active high
// ---------------------------------------------------------------------------
module pio_in_edge_irq #(
  parameter int unsigned W               = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned EDGE_TYPE       = 0   // 0 rising, 1 falling, 2 any
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    address,
  input  logic          chipselect,
  input  logic          write_n,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  input  logic [W-1:0]  in_port,
  output logic          irq
);

  // Counter is wide enough to hold DEBOUNCE_CYCLES-1; the terminal value is
  // compared rather than a wrapped count so any DEBOUNCE_CYCLES >= 1 works.
  localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ADDR_DATA      = 2'd0,
    ADDR_DIRECTION = 2'd1,
    ADDR_IRQ_MASK  = 2'd2,
    ADDR_EDGE_CAP  = 2'd3
  } reg_addr_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [W-1:0]         sync1_q;
  logic [W-1:0]         sync2_q;
  logic [W-1:0]         deb_q,      deb_d;
  logic [W-1:0]         deb_prev_q;
  logic [W-1:0][CW-1:0] cnt_q,      cnt_d;
  logic [W-1:0]         irq_mask_q, irq_mask_d;
  logic [W-1:0]         edge_cap_q, edge_cap_d;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic      wr_en;
  reg_addr_e addr;
  logic [W-1:0] wdata_w;

  assign wr_en   = chipselect & ~write_n;
  assign addr    = reg_addr_e'(address);
  assign wdata_w = writedata[W-1:0];

  // Bits of writedata above W carry no register state; folding the whole bus
  // into one named sink keeps the intent explicit for any W.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // -------------------------------------------------------------------------
  // Debounce: per-bit saturating counter of consecutive disagreement cycles.
  // Any cycle where the synchronised input agrees with the debounced level
  // restarts the count, so a bounce back before the threshold is discarded.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < int'(W); i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Edge detection on the debounced level
  // -------------------------------------------------------------------------
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] sel;

  assign rise = deb_q & ~deb_prev_q;
  assign fall = ~deb_q & deb_prev_q;

  always_comb begin
    sel = '0;
    case (EDGE_TYPE)
      0:       sel = rise;
      1:       sel = fall;
      default: sel = rise | fall;
    endcase
  end

  // -------------------------------------------------------------------------
  // Software-visible registers
  // -------------------------------------------------------------------------
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr_en && addr == ADDR_IRQ_MASK) begin
      irq_mask_d = wdata_w;
    end
  end

  // The clear is applied before OR-ing in new edges, so an edge arriving in
  // the same cycle as a W1C write survives and software cannot lose it.
  always_comb begin
    logic [W-1:0] clr;
    clr = '0;
    if (wr_en && addr == ADDR_EDGE_CAP) begin
      clr = wdata_w;
    end
    edge_cap_d = (edge_cap_q & ~clr) | sel;
  end

  // -------------------------------------------------------------------------
  // Register update
  // -------------------------------------------------------------------------
  // NOTE: non-blocking assignments in clocked blocks so every flop samples
  // the pre-edge value of its source; blocking here would collapse the
  // two-stage synchroniser into a single stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the per-bit counters form a small register array, not a RAM,
      // so they are reset along with everything else; this is what lets a
      // reset abort a debounce that was in progress.
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read mux: address only, zero wait states
  // -------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (addr)
      ADDR_DATA:      readdata = 32'(deb_q);
      ADDR_DIRECTION: readdata = '0;
      ADDR_IRQ_MASK:  readdata = 32'(irq_mask_q);
      ADDR_EDGE_CAP:  readdata = 32'(edge_cap_q);
      default:        readdata = '0;
    endcase
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule
